fnd_scan_driver: RTL and testbench
==================================

// Module: fnd_scan_driver
// PURPOSE
//  Multiplexed 8-digit FND driver for the GALAGA score/timer display. Consumes the binary
//  score and the three BCD timer digits. Converts the score to BCD with a sequential
//  shift-add-3 (double-dabble) engine. Scans the 8 digits one at a time onto a shared
//  active-low segment bus. Sits between the game timer/score logic and the board FND pins.
// PARAMETERS
//  SCAN_DIV  100_000  i_Clk cycles per digit slot (1 kHz digit rate at 100 MHz); must be >= 2
// PORTS
//  i_Clk         in   1   system clock; all state changes on its rising edge
//  i_Rst         in   1   reset, asynchronous, active-high
//  i_Score       in   14  binary score (0..16383)
//  i_ScoreValid  in   1   one-cycle strobe: convert i_Score
//  i_Sec0        in   4   timer ones digit, BCD
//  i_Sec1        in   4   timer tens digit, BCD
//  i_Sec2        in   4   timer hundreds digit, BCD
//  i_Blank       in   1   level: blank the whole display
//  o_Busy        out  1   BCD conversion in progress
//  o_ScoreBcd    out  16  last converted score, 4 BCD nibbles (thousands in [15:12])
//  o_DigitEn     out  8   digit enables, active-low, one-cold; bit0 = rightmost digit
//  o_Seg         out  7   segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//  Reset (async): o_Seg=7'h7F, o_DigitEn=8'hFF, o_ScoreBcd=0, o_Busy=0, FSM=IDLE,
//   pending flag=0, scan index=0, prescaler=0. Asserting reset mid-conversion aborts it.
//  Converter FSM, states IDLE/SHIFT/DONE:
//   IDLE: i_ScoreValid=1 -> load min(i_Score,9999) into 30-bit reg {bcd16,bin14}.
//    Set shift count=0, o_Busy<=1, go to SHIFT.
//   SHIFT: per cycle, add 3 to every BCD nibble >=5, then shift the reg left 1.
//    After the 14th shift go to DONE.
//   DONE: o_ScoreBcd<=bcd16. Then load the next job, if any, and go to SHIFT with o_Busy
//    held at 1. Job priority: i_ScoreValid this cycle, else pending. Otherwise o_Busy<=0
//    and go to IDLE.
//   Latency: strobe sampled at edge E0 -> o_Busy high after E0.
//    o_ScoreBcd updated and o_Busy low after E15 (15 busy cycles).
//   i_ScoreValid in SHIFT: stored in a 1-deep pending reg with pending flag=1.
//    A later strobe overwrites the stored score (last wins). DONE clears the flag when it
//    consumes the job. A strobe in DONE takes the job and discards the older pending score.
//   Saturation: i_Score>9999 converts as 9999 (16'h9999).
//  Scan:
//   Prescaler counts 0..SCAN_DIV-1. At the terminal count: prescaler->0, and the index
//    advances 0..7, then wraps 7->0.
//   Digit map: idx0..3 = score ones..thousands, idx4 = blank, idx5..7 = i_Sec0..i_Sec2.
//   o_DigitEn and o_Seg are registered from the current index. Both change on the same
//    edge, one cycle after the index changes.
//   First enable after reset release: 8'hFE.
//   Encoding 0-9 (hex): 40,79,24,30,19,12,02,78,00,10.
//   Timer digit >9 shows dash 7'h3F. Blank slot = 7'h7F.
//   Leading-zero suppression: thousands, hundreds and tens show 7'h7F while they and all
//    higher score digits are 0. Ones is always shown.
//   The score display uses o_ScoreBcd, so it never shows a partial conversion.
//   i_Blank=1: o_DigitEn=8'hFF and o_Seg=7'h7F from the next edge. Scan and conversion
//    keep running.
// TESTING
//  T1 reset, release, i_Blank=0 -> o_DigitEn=8'hFE, o_Seg=7'h40; o_Busy=0, o_ScoreBcd=0.
//  T2 i_Score=1234 strobe -> o_Busy high 15 cycles, then o_ScoreBcd=16'h1234.
//  T3 i_Score=16383 -> o_ScoreBcd=16'h9999; i_Score=0 -> 16'h0000.
//  T4 strobes 100, then 200 and 300 while busy -> o_ScoreBcd 16'h0100, then 16'h0300.
//     o_Busy stays high throughout; 200 is never shown.
//  T5 SCAN_DIV=4, score 7, Sec={2,A,5} (Sec2,Sec1,Sec0) -> over one frame per idx0..7:
//     o_Seg = 78,7F,7F,7F,7F,12,3F,24. Enables FE,FD,..,7F, each held 4 cycles, then wrap to FE.
//  T6 reset asserted mid-SHIFT after a 9999 strobe -> outputs at reset values immediately,
//     o_ScoreBcd=0 after release. i_Blank=1 -> o_DigitEn=FF, o_Seg=7F.

Source files
------------

// File: rtl/fnd_scan_if.sv
// Bus between the game score/timer logic and the FND scan driver.
// The master drives the score and timer inputs; the slave (driver) returns status and pin drives.
interface fnd_scan_if;
    logic [13:0] i_Score;
    logic        i_ScoreValid;
    logic [3:0]  i_Sec0;
    logic [3:0]  i_Sec1;
    logic [3:0]  i_Sec2;
    logic        i_Blank;
    logic        o_Busy;
    logic [15:0] o_ScoreBcd;
    logic [7:0]  o_DigitEn;
    logic [6:0]  o_Seg;

    modport master (
        output i_Score, i_ScoreValid, i_Sec0, i_Sec1, i_Sec2, i_Blank,
        input  o_Busy, o_ScoreBcd, o_DigitEn, o_Seg
    );

    modport slave (
        input  i_Score, i_ScoreValid, i_Sec0, i_Sec1, i_Sec2, i_Blank,
        output o_Busy, o_ScoreBcd, o_DigitEn, o_Seg
    );
endinterface

// File: rtl/fnd_scan_driver.sv
// 8-digit multiplexed FND driver: sequential double-dabble score converter plus
// a digit scanner driving a shared active-low segment bus.
module fnd_scan_driver #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    fnd_scan_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    function automatic logic [6:0] seg_enc(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h3F;
        endcase
        return seg;
    endfunction

    function automatic logic [13:0] sat_score(input logic [13:0] score);
        return (score > 14'd9999) ? 14'd9999 : score;
    endfunction

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
    function automatic logic [29:0] dabble_step(input logic [29:0] sr);
        logic [29:0] adj;
        adj = sr;
        for (int n = 0; n < 4; n++) begin
            if (adj[14 + 4*n +: 4] >= 4'd5) begin
                adj[14 + 4*n +: 4] = adj[14 + 4*n +: 4] + 4'd3;
            end else begin
                adj[14 + 4*n +: 4] = adj[14 + 4*n +: 4];
            end
        end
        return {adj[28:0], 1'b0};
    endfunction

    logic [1:0]    state_r;
    logic [29:0]   shreg_r;
    logic [3:0]    shift_cnt_r;
    logic          busy_r;
    logic [15:0]   score_bcd_r;
    logic          pend_flag_r;
    logic [13:0]   pend_score_r;
    logic          job_valid_s;
    logic [13:0]   job_score_s;

    logic [PW-1:0] presc_r;
    logic [2:0]    idx_r;
    logic [7:0]    digit_en_r;
    logic [6:0]    seg_r;
    logic [6:0]    slot_seg_s;

    // Next conversion job when leaving DONE: a fresh strobe beats the pending score.
    always_comb begin
        job_valid_s = 1'b0;
        job_score_s = 14'd0;
        if (bus.i_ScoreValid) begin
            job_valid_s = 1'b1;
            job_score_s = bus.i_Score;
        end else if (pend_flag_r) begin
            job_valid_s = 1'b1;
            job_score_s = pend_score_r;
        end else begin
            job_valid_s = 1'b0;
            job_score_s = 14'd0;
        end
    end

    // Converter FSM with 1-deep pending job register.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_r      <= ST_IDLE;
            shreg_r      <= 30'd0;
            shift_cnt_r  <= 4'd0;
            busy_r       <= 1'b0;
            score_bcd_r  <= 16'd0;
            pend_flag_r  <= 1'b0;
            pend_score_r <= 14'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.i_ScoreValid) begin
                        shreg_r     <= {16'd0, sat_score(bus.i_Score)};
                        shift_cnt_r <= 4'd0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_SHIFT;
                    end else begin
                        busy_r      <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    shreg_r     <= dabble_step(shreg_r);
                    shift_cnt_r <= shift_cnt_r + 4'd1;
                    if (shift_cnt_r == 4'd13) begin
                        state_r <= ST_DONE;
                    end
                    if (bus.i_ScoreValid) begin
                        pend_score_r <= bus.i_Score;
                        pend_flag_r  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    score_bcd_r <= shreg_r[29:14];
                    pend_flag_r <= 1'b0;
                    if (job_valid_s) begin
                        shreg_r     <= {16'd0, sat_score(job_score_s)};
                        shift_cnt_r <= 4'd0;
                        state_r     <= ST_SHIFT;
                    end else begin
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Digit-slot prescaler and scan index.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            presc_r <= '0;
            idx_r   <= 3'd0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= '0;
            idx_r   <= idx_r + 3'd1;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Segment pattern for the current slot, with leading-zero suppression on the score.
    always_comb begin
        slot_seg_s = 7'h7F;
        case (idx_r)
            3'd0: slot_seg_s = seg_enc(score_bcd_r[3:0]);
            3'd1: slot_seg_s = (score_bcd_r[15:4] != 12'd0) ? seg_enc(score_bcd_r[7:4]) : 7'h7F;
            3'd2: slot_seg_s = (score_bcd_r[15:8] != 8'd0) ? seg_enc(score_bcd_r[11:8]) : 7'h7F;
            3'd3: slot_seg_s = (score_bcd_r[15:12] != 4'd0) ? seg_enc(score_bcd_r[15:12]) : 7'h7F;
            3'd4: slot_seg_s = 7'h7F;
            3'd5: slot_seg_s = seg_enc(bus.i_Sec0);
            3'd6: slot_seg_s = seg_enc(bus.i_Sec1);
            3'd7: slot_seg_s = seg_enc(bus.i_Sec2);
            default: slot_seg_s = 7'h7F;
        endcase
    end

    // Registered pin drives; blanking overrides the scan.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            digit_en_r <= 8'hFF;
            seg_r      <= 7'h7F;
        end else if (bus.i_Blank) begin
            digit_en_r <= 8'hFF;
            seg_r      <= 7'h7F;
        end else begin
            digit_en_r <= ~(8'h01 << idx_r);
            seg_r      <= slot_seg_s;
        end
    end

    assign bus.o_Busy     = busy_r;
    assign bus.o_ScoreBcd = score_bcd_r;
    assign bus.o_DigitEn  = digit_en_r;
    assign bus.o_Seg      = seg_r;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed self-checking bench for fnd_scan_driver (SCAN_DIV = 4).
module tb_fnd_scan_driver;

    logic i_Clk;
    logic i_Rst;
    int   errors;
    int   checks;

    fnd_scan_if bus_if ();

    fnd_scan_driver #(.SCAN_DIV(4)) dut (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .bus   (bus_if)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Strobe one score and wait (bounded) for the conversion to finish.
    task automatic convert(input logic [13:0] val);
        int k;
        @(negedge i_Clk);
        bus_if.i_Score      = val;
        bus_if.i_ScoreValid = 1'b1;
        @(negedge i_Clk);
        bus_if.i_ScoreValid = 1'b0;
        k = 0;
        while (bus_if.o_Busy && k < 100) begin
            @(negedge i_Clk);
            k++;
        end
        checks++;
        if (k >= 100) begin
            errors++;
            $display("FAIL convert_timeout: busy still %0b after %0d cycles, required 0", bus_if.o_Busy, k);
        end
    endtask

    task automatic test_reset;
        i_Rst               = 1'b1;
        bus_if.i_Score      = 14'd0;
        bus_if.i_ScoreValid = 1'b0;
        bus_if.i_Sec0       = 4'd0;
        bus_if.i_Sec1       = 4'd0;
        bus_if.i_Sec2       = 4'd0;
        bus_if.i_Blank      = 1'b0;
        repeat (3) @(negedge i_Clk);
        checks++;
        if (bus_if.o_DigitEn !== 8'hFF || bus_if.o_Seg !== 7'h7F) begin
            errors++;
            $display("FAIL reset_pins: en=%h seg=%h, required FF 7F", bus_if.o_DigitEn, bus_if.o_Seg);
        end
        i_Rst = 1'b0;
        @(negedge i_Clk);
        checks++;
        if (bus_if.o_DigitEn !== 8'hFE || bus_if.o_Seg !== 7'h40) begin
            errors++;
            $display("FAIL first_scan: en=%h seg=%h, required FE 40", bus_if.o_DigitEn, bus_if.o_Seg);
        end
        checks++;
        if (bus_if.o_Busy !== 1'b0 || bus_if.o_ScoreBcd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_conv: busy=%b bcd=%h, required 0 0000", bus_if.o_Busy, bus_if.o_ScoreBcd);
        end
    endtask

    task automatic test_convert_latency;
        int k;
        @(negedge i_Clk);
        bus_if.i_Score      = 14'd1234;
        bus_if.i_ScoreValid = 1'b1;
        @(negedge i_Clk);
        bus_if.i_ScoreValid = 1'b0;
        k = 0;
        while (bus_if.o_Busy && k < 100) begin
            k++;
            @(negedge i_Clk);
        end
        checks++;
        if (k !== 15) begin
            errors++;
            $display("FAIL busy_len: busy cycles=%0d, required 15", k);
        end
        checks++;
        if (bus_if.o_ScoreBcd !== 16'h1234) begin
            errors++;
            $display("FAIL bcd_1234: got %h, required 1234", bus_if.o_ScoreBcd);
        end
    endtask

    task automatic test_saturation;
        convert(14'd16383);
        checks++;
        if (bus_if.o_ScoreBcd !== 16'h9999) begin
            errors++;
            $display("FAIL bcd_sat: got %h, required 9999", bus_if.o_ScoreBcd);
        end
        convert(14'd0);
        checks++;
        if (bus_if.o_ScoreBcd !== 16'h0000) begin
            errors++;
            $display("FAIL bcd_zero: got %h, required 0000", bus_if.o_ScoreBcd);
        end
    endtask

    task automatic test_back_to_back;
        int          k;
        int          busy_cnt;
        logic        seen_200;
        logic        first_seen;
        logic        busy_at_first;
        logic [15:0] first_val;
        @(negedge i_Clk);
        bus_if.i_Score      = 14'd100;
        bus_if.i_ScoreValid = 1'b1;
        @(negedge i_Clk);
        k             = 0;
        busy_cnt      = 0;
        seen_200      = 1'b0;
        first_seen    = 1'b0;
        busy_at_first = 1'b0;
        first_val     = 16'h0000;
        while (bus_if.o_Busy && k < 200) begin
            busy_cnt++;
            if (bus_if.o_ScoreBcd == 16'h0200) seen_200 = 1'b1;
            if (!first_seen && bus_if.o_ScoreBcd != 16'h0000) begin
                first_seen    = 1'b1;
                first_val     = bus_if.o_ScoreBcd;
                busy_at_first = bus_if.o_Busy;
            end
            case (k)
                0:       begin bus_if.i_Score = 14'd200; bus_if.i_ScoreValid = 1'b1; end
                2:       begin bus_if.i_Score = 14'd300; bus_if.i_ScoreValid = 1'b1; end
                default: bus_if.i_ScoreValid = 1'b0;
            endcase
            k++;
            @(negedge i_Clk);
        end
        bus_if.i_ScoreValid = 1'b0;
        checks++;
        if (first_val !== 16'h0100 || busy_at_first !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: bcd=%h busy=%b, required 0100 1", first_val, busy_at_first);
        end
        checks++;
        if (busy_cnt !== 30) begin
            errors++;
            $display("FAIL b2b_busy: busy cycles=%0d, required 30", busy_cnt);
        end
        checks++;
        if (bus_if.o_ScoreBcd !== 16'h0300 || seen_200) begin
            errors++;
            $display("FAIL b2b_last: bcd=%h seen_200=%b, required 0300 0", bus_if.o_ScoreBcd, seen_200);
        end
    endtask

    task automatic test_scan;
        logic [6:0] exp_seg [8];
        logic [7:0] prev;
        logic [7:0] exp_en;
        int         k;
        exp_seg = '{7'h78, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h12, 7'h3F, 7'h24};
        bus_if.i_Sec0 = 4'h5;
        bus_if.i_Sec1 = 4'hA;
        bus_if.i_Sec2 = 4'h2;
        convert(14'd7);
        k    = 0;
        prev = bus_if.o_DigitEn;
        @(negedge i_Clk);
        while (!(bus_if.o_DigitEn == 8'hFE && prev != 8'hFE) && k < 100) begin
            prev = bus_if.o_DigitEn;
            k++;
            @(negedge i_Clk);
        end
        checks++;
        if (k >= 100) begin
            errors++;
            $display("FAIL scan_sync: en=%h, required FE within 100 cycles", bus_if.o_DigitEn);
        end
        for (int s = 0; s < 8; s++) begin
            exp_en = 8'hFF;
            exp_en[s] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                checks++;
                if (bus_if.o_DigitEn !== exp_en || bus_if.o_Seg !== exp_seg[s]) begin
                    errors++;
                    $display("FAIL scan_slot%0d_c%0d: en=%h seg=%h, required %h %h",
                             s, c, bus_if.o_DigitEn, bus_if.o_Seg, exp_en, exp_seg[s]);
                end
                @(negedge i_Clk);
            end
        end
        checks++;
        if (bus_if.o_DigitEn !== 8'hFE || bus_if.o_Seg !== 7'h78) begin
            errors++;
            $display("FAIL scan_wrap: en=%h seg=%h, required FE 78", bus_if.o_DigitEn, bus_if.o_Seg);
        end
    endtask

    task automatic test_reset_abort_blank;
        @(negedge i_Clk);
        bus_if.i_Score      = 14'd9999;
        bus_if.i_ScoreValid = 1'b1;
        @(negedge i_Clk);
        bus_if.i_ScoreValid = 1'b0;
        repeat (4) @(negedge i_Clk);
        checks++;
        if (bus_if.o_Busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy: busy=%b, required 1", bus_if.o_Busy);
        end
        #2 i_Rst = 1'b1;
        #1;
        checks++;
        if (bus_if.o_DigitEn !== 8'hFF || bus_if.o_Seg !== 7'h7F ||
            bus_if.o_Busy !== 1'b0 || bus_if.o_ScoreBcd !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: en=%h seg=%h busy=%b bcd=%h, required FF 7F 0 0000",
                     bus_if.o_DigitEn, bus_if.o_Seg, bus_if.o_Busy, bus_if.o_ScoreBcd);
        end
        @(negedge i_Clk);
        i_Rst = 1'b0;
        repeat (20) @(negedge i_Clk);
        checks++;
        if (bus_if.o_ScoreBcd !== 16'h0000 || bus_if.o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_result: bcd=%h busy=%b, required 0000 0", bus_if.o_ScoreBcd, bus_if.o_Busy);
        end
        bus_if.i_Blank = 1'b1;
        @(negedge i_Clk);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (bus_if.o_DigitEn !== 8'hFF || bus_if.o_Seg !== 7'h7F) begin
                errors++;
                $display("FAIL blank_c%0d: en=%h seg=%h, required FF 7F", c, bus_if.o_DigitEn, bus_if.o_Seg);
            end
            @(negedge i_Clk);
        end
        bus_if.i_Blank = 1'b0;
        @(negedge i_Clk);
        checks++;
        if (bus_if.o_DigitEn === 8'hFF) begin
            errors++;
            $display("FAIL unblank: en=%h, required a one-cold enable", bus_if.o_DigitEn);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_convert_latency();
        test_saturation();
        test_back_to_back();
        test_scan();
        test_reset_abort_blank();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
